// File: rtl/dsp_mac_pkg.sv
// Shared widths, pipeline latency and FSM state type for the pre-subtract
// dot-product sequencer and its DSP slice.
package dsp_mac_pkg;
  localparam int A_W       = 25;
  localparam int D_W       = 30;
  localparam int B_W       = 18;
  localparam int P_W       = 48;
  localparam int M_W       = A_W + B_W;
  localparam int DSP_M_LAT = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } mac_state_t;
endpackage

// File: rtl/dsp_25x18_presub.sv
// DSP slice: registered (a - d) pre-subtract, 25x18 multiply, and an
// accumulator p = m + pci with an optional pci input register.
module dsp_25x18_presub
  import dsp_mac_pkg::*;
#(
  parameter bit USE_PCI_REG = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic signed [A_W-1:0] a,
  input  logic signed [D_W-1:0] d,
  input  logic signed [B_W-1:0] b,
  input  logic signed [P_W-1:0] pci,
  output logic signed [P_W-1:0] p
);

  logic signed [A_W-1:0] a_r;
  logic signed [D_W-1:0] d_r;
  logic signed [B_W-1:0] b_r;
  logic signed [A_W-1:0] ad_r;
  logic signed [B_W-1:0] b2_r;
  logic signed [M_W-1:0] m_r;
  logic signed [P_W-1:0] p_r;
  logic signed [P_W-1:0] pci_s;
  logic signed [D_W-1:0] diff_s;

  // The difference wraps to 25 bits, exactly as the hard pre-adder does.
  assign diff_s = D_W'(a_r) - d_r;

  generate
    if (USE_PCI_REG) begin : g_pci_reg
      logic signed [P_W-1:0] pci_r;
      // Optional pci capture register.
      always_ff @(posedge clk) begin
        if (rst) begin
          pci_r <= {P_W{1'b0}};
        end else begin
          pci_r <= pci;
        end
      end
      assign pci_s = pci_r;
    end else begin : g_pci_comb
      assign pci_s = pci;
    end
  endgenerate

  // Input, pre-subtract, multiply and accumulate pipeline stages.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r  <= {A_W{1'b0}};
      d_r  <= {D_W{1'b0}};
      b_r  <= {B_W{1'b0}};
      ad_r <= {A_W{1'b0}};
      b2_r <= {B_W{1'b0}};
      m_r  <= {M_W{1'b0}};
      p_r  <= {P_W{1'b0}};
    end else begin
      a_r  <= a;
      d_r  <= d;
      b_r  <= b;
      ad_r <= A_W'(diff_s);
      b2_r <= b_r;
      m_r  <= ad_r * b2_r;
      p_r  <= P_W'(m_r) + pci_s;
    end
  end

  assign p = p_r;

endmodule

// File: rtl/dsp_presub_mac_seq.sv
// Dot-product sequencer: streams len operand triples from a 1-cycle-latency
// memory into one pre-subtract DSP and returns the accumulated sum via valid/ready.
module dsp_presub_mac_seq
  import dsp_mac_pkg::*;
#(
  parameter int MAX_LEN = 256,
  parameter int ADDR_W  = $clog2(MAX_LEN)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_W:0]       len,
  output logic                  busy,
  output logic                  err_len,
  output logic                  rd_en,
  output logic [ADDR_W-1:0]     rd_addr,
  input  logic signed [A_W-1:0] rd_a,
  input  logic signed [D_W-1:0] rd_d,
  input  logic signed [B_W-1:0] rd_b,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic signed [P_W-1:0] res_data
);

  localparam logic [ADDR_W:0] LEN_MAX  = (ADDR_W+1)'(MAX_LEN);
  localparam logic [ADDR_W:0] LEN_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] LEN_ZERO = (ADDR_W+1)'(0);

  mac_state_t            state_r;
  mac_state_t            state_s;
  logic [ADDR_W:0]       len_r;
  logic                  rd_en_r;
  logic [ADDR_W-1:0]     rd_addr_r;
  logic                  busy_r;
  logic                  err_len_r;
  logic                  res_valid_r;
  logic signed [P_W-1:0] res_data_r;
  logic [DSP_M_LAT-1:0]  vld_sr_r;
  logic [DSP_M_LAT-1:0]  first_sr_r;
  logic [DSP_M_LAT:0]    last_sr_r;
  logic signed [P_W-1:0] p_s;
  logic signed [P_W-1:0] pci_s;
  logic                  len_ok_s;
  logic                  last_issue_s;

  assign len_ok_s     = (len != LEN_ZERO) && (len <= LEN_MAX);
  assign last_issue_s = ({1'b0, rd_addr_r} == (len_r - LEN_ONE));

  // A valid first-element tag restarts the accumulation; otherwise feed p back.
  assign pci_s = (vld_sr_r[DSP_M_LAT-1] && first_sr_r[DSP_M_LAT-1]) ? {P_W{1'b0}} : p_s;

  dsp_25x18_presub #(
    .USE_PCI_REG (1'b0)
  ) u_dsp (
    .clk (clk),
    .rst (rst),
    .a   (rd_a),
    .d   (rd_d),
    .b   (rd_b),
    .pci (pci_s),
    .p   (p_s)
  );

  // Next-state selection.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start && len_ok_s) begin
          state_s = ISSUE;
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        if (last_issue_s) begin
          state_s = DRAIN;
        end else begin
          state_s = ISSUE;
        end
      end
      DRAIN: begin
        if (last_sr_r[DSP_M_LAT]) begin
          state_s = HOLD;
        end else begin
          state_s = DRAIN;
        end
      end
      HOLD: begin
        if (res_ready) begin
          state_s = IDLE;
        end else begin
          state_s = HOLD;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State register and registered control/result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      len_r       <= LEN_ZERO;
      rd_en_r     <= 1'b0;
      rd_addr_r   <= {ADDR_W{1'b0}};
      busy_r      <= 1'b0;
      err_len_r   <= 1'b0;
      res_valid_r <= 1'b0;
      res_data_r  <= {P_W{1'b0}};
    end else begin
      state_r     <= state_s;
      busy_r      <= (state_s != IDLE);
      rd_en_r     <= (state_s == ISSUE);
      res_valid_r <= (state_s == HOLD);
      err_len_r   <= (state_r == IDLE) && start && !len_ok_s;
      if ((state_r == IDLE) && (state_s == ISSUE)) begin
        len_r <= len;
      end
      if ((state_r == ISSUE) && (state_s == ISSUE)) begin
        rd_addr_r <= rd_addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
      end else begin
        rd_addr_r <= {ADDR_W{1'b0}};
      end
      if ((state_r == DRAIN) && last_sr_r[DSP_M_LAT]) begin
        res_data_r <= p_s;
      end
    end
  end

  // Tags ride alongside the DSP pipeline; last gets one extra stage to mark p.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_sr_r   <= {DSP_M_LAT{1'b0}};
      first_sr_r <= {DSP_M_LAT{1'b0}};
      last_sr_r  <= {(DSP_M_LAT+1){1'b0}};
    end else begin
      vld_sr_r   <= {vld_sr_r[DSP_M_LAT-2:0], rd_en_r};
      first_sr_r <= {first_sr_r[DSP_M_LAT-2:0], rd_en_r && (rd_addr_r == {ADDR_W{1'b0}})};
      last_sr_r  <= {last_sr_r[DSP_M_LAT-1:0], rd_en_r && last_issue_s};
    end
  end

  assign busy      = busy_r;
  assign err_len   = err_len_r;
  assign rd_en     = rd_en_r;
  assign rd_addr   = rd_addr_r;
  assign res_valid = res_valid_r;
  assign res_data  = res_data_r;

endmodule

// File: tb/tb_dsp_presub_mac_seq.sv
// Self-checking bench for dsp_presub_mac_seq: directed spec scenarios plus
// randomized runs against an arithmetic dot-product reference.
module tb_dsp_presub_mac_seq;

  localparam int MAX_LEN = 256;
  localparam int ADDR_W  = 8;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [ADDR_W:0]    len;
  logic               busy;
  logic               err_len;
  logic               rd_en;
  logic [ADDR_W-1:0]  rd_addr;
  logic signed [24:0] rd_a;
  logic signed [29:0] rd_d;
  logic signed [17:0] rd_b;
  logic               res_valid;
  logic               res_ready;
  logic signed [47:0] res_data;

  logic signed [24:0] mem_a [0:MAX_LEN-1];
  logic signed [29:0] mem_d [0:MAX_LEN-1];
  logic signed [17:0] mem_b [0:MAX_LEN-1];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  dsp_presub_mac_seq #(.MAX_LEN(MAX_LEN), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy), .err_len(err_len),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_a(rd_a), .rd_d(rd_d), .rd_b(rd_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
  );

  // Operand memory, 1-cycle read latency; junk on the bus when not reading.
  always @(posedge clk) begin
    if (rd_en === 1'b1) begin
      rd_a <= mem_a[rd_addr];
      rd_d <= mem_d[rd_addr];
      rd_b <= mem_b[rd_addr];
    end else begin
      rd_a <= 25'($urandom);
      rd_d <= 30'($urandom);
      rd_b <= 18'($urandom);
    end
  end

  // Reference: sum of wrap25(a - d) * b, reduced modulo 2^48.
  function automatic logic [47:0] ref_dot(input int n);
    longint acc = 0;
    for (int i = 0; i < n; i++) begin
      longint diff = longint'(mem_a[i]) - longint'(mem_d[i]);
      diff = ((diff % 64'sd33554432) + 64'sd33554432) % 64'sd33554432;
      if (diff >= 64'sd16777216) diff = diff - 64'sd33554432;
      acc = acc + diff * longint'(mem_b[i]);
    end
    return acc[47:0];
  endfunction

  task automatic set_op(input int i, input int a, input int d, input int b);
    mem_a[i] = 25'(a);
    mem_d[i] = 30'(d);
    mem_b[i] = 18'(b);
  endtask

  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++) begin
      mem_a[i] = 25'($urandom);
      mem_d[i] = 30'($urandom);
      mem_b[i] = 18'($urandom);
    end
  endtask

  // Starts a run (start cycle = 0) and records when res_valid rises, the
  // result, and how many cycles broke the rd_en/rd_addr issue pattern.
  task automatic run_op(input int n, output int lat, output logic [47:0] data, output int rd_bad);
    lat = -1;
    data = 48'd0;
    rd_bad = 0;
    @(negedge clk);
    start = 1'b1;
    len = 9'(n);
    for (int k = 1; k <= n + 30; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (rd_en !== ((k <= n) ? 1'b1 : 1'b0)) rd_bad++;
      else if ((rd_en === 1'b1) && (rd_addr !== 8'(k - 1))) rd_bad++;
      if (res_valid === 1'b1) begin
        lat = k;
        data = res_data;
        break;
      end
    end
  endtask

  task automatic handshake(output logic v, output logic b);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    v = res_valid;
    b = busy;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    tests++;
    if ({busy, err_len, rd_en, res_valid} !== 4'b0000) begin
      fails++;
      $display("FAIL reset_flags: got %b expected 0000", {busy, err_len, rd_en, res_valid});
    end
    tests++;
    if (rd_addr !== 8'd0) begin
      fails++;
      $display("FAIL reset_addr: got %0d expected 0", rd_addr);
    end
    tests++;
    if (res_data !== 48'd0) begin
      fails++;
      $display("FAIL reset_data: got %0d expected 0", res_data);
    end
  endtask

  // Common directed run: latency, result, issue pattern and handshake return.
  task automatic test_directed(input string name, input int n, input logic [47:0] exp);
    int lat;
    int rd_bad;
    logic [47:0] data;
    logic v;
    logic b;
    run_op(n, lat, data, rd_bad);
    tests++;
    if (lat !== n + 6) begin
      fails++;
      $display("FAIL %s_latency: got %0d expected %0d", name, lat, n + 6);
    end
    tests++;
    if (data !== exp) begin
      fails++;
      $display("FAIL %s_data: got %0d expected %0d", name, $signed(data), $signed(exp));
    end
    tests++;
    if (rd_bad !== 0) begin
      fails++;
      $display("FAIL %s_issue: got %0d bad cycles expected 0", name, rd_bad);
    end
    handshake(v, b);
    tests++;
    if ({v, b} !== 2'b00) begin
      fails++;
      $display("FAIL %s_return: got valid/busy %b expected 00", name, {v, b});
    end
  endtask

  task automatic test_len1;
    set_op(0, 10, 3, 5);
    test_directed("len1", 1, 48'd35);
  endtask

  task automatic test_len3;
    set_op(0, 7, 2, 4);
    set_op(1, -5, 1, 3);
    set_op(2, 100, 0, -2);
    test_directed("len3", 3, -48'sd198);
  endtask

  task automatic test_truncation;
    set_op(0, -16777216, 1, 1);
    test_directed("trunc", 1, 48'd16777215);
  endtask

  task automatic test_random;
    for (int r = 0; r < 7; r++) begin
      int n;
      n = (r == 6) ? MAX_LEN : int'($urandom_range(24, 1));
      fill_random(n);
      test_directed("random", n, ref_dot(n));
    end
  endtask

  task automatic test_backpressure;
    int lat;
    int rd_bad;
    logic [47:0] data;
    logic [47:0] exp;
    logic v;
    logic b;
    fill_random(2);
    exp = ref_dot(2);
    run_op(2, lat, data, rd_bad);
    tests++;
    if (data !== exp) begin
      fails++;
      $display("FAIL bp_data: got %0d expected %0d", $signed(data), $signed(exp));
    end
    for (int c = 0; c < 5; c++) begin
      start = 1'b1;
      len = 9'd1;
      @(negedge clk);
      tests++;
      if ({res_valid, rd_en, busy} !== 3'b101 || res_data !== exp) begin
        fails++;
        $display("FAIL bp_hold: got v/rd/busy %b data %0d expected 101 data %0d",
                 {res_valid, rd_en, busy}, $signed(res_data), $signed(exp));
      end
    end
    handshake(v, b);
    start = 1'b0;
    tests++;
    if ({v, b} !== 2'b00) begin
      fails++;
      $display("FAIL bp_return: got valid/busy %b expected 00", {v, b});
    end
    @(negedge clk);
    tests++;
    if ({rd_en, busy} !== 2'b00) begin
      fails++;
      $display("FAIL bp_no_restart: got rd/busy %b expected 00", {rd_en, busy});
    end
  endtask

  task automatic test_back_to_back;
    set_op(0, 5, 0, 5);
    set_op(1, 5, 0, 5);
    test_directed("b2b_first", 2, 48'd50);
    set_op(0, 3, 0, 2);
    test_directed("b2b_second", 1, 48'd6);
  endtask

  task automatic test_err_len(input int bad_len);
    int seen_rd;
    @(negedge clk);
    start = 1'b1;
    len = 9'(bad_len);
    @(negedge clk);
    start = 1'b0;
    tests++;
    if ({err_len, busy} !== 2'b10) begin
      fails++;
      $display("FAIL err_pulse len=%0d: got err/busy %b expected 10", bad_len, {err_len, busy});
    end
    seen_rd = 0;
    @(negedge clk);
    tests++;
    if (err_len !== 1'b0) begin
      fails++;
      $display("FAIL err_one_cycle len=%0d: got %b expected 0", bad_len, err_len);
    end
    for (int c = 0; c < 5; c++) begin
      if (rd_en !== 1'b0 || busy !== 1'b0) seen_rd++;
      @(negedge clk);
    end
    tests++;
    if (seen_rd !== 0) begin
      fails++;
      $display("FAIL err_no_run len=%0d: got %0d active cycles expected 0", bad_len, seen_rd);
    end
  endtask

  task automatic test_reset_mid;
    int bad;
    fill_random(4);
    @(negedge clk);
    start = 1'b1;
    len = 9'd4;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int c = 0; c < 15; c++) begin
      if (res_valid !== 1'b0 || rd_en !== 1'b0 || busy !== 1'b0) bad++;
      @(negedge clk);
    end
    tests++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL midreset_quiet: got %0d active cycles expected 0", bad);
    end
    set_op(0, 4, 1, 2);
    test_directed("after_reset", 1, 48'd6);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    len = 9'd0;
    res_ready = 1'b0;
    test_reset;
    test_len1;
    test_len3;
    test_truncation;
    test_backpressure;
    test_back_to_back;
    test_err_len(0);
    test_err_len(257);
    test_reset_mid;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dsp_presub_mac_seq.md
Name: dsp_presub_mac_seq

Overview:
- Sequencer that computes one dot product per run on a single dsp_25x18_presub: sum over i of (a_i - d_i) * b_i, for i = 0..len-1.
- Reads operand triples from an external synchronous operand memory with 1-cycle read latency and streams them into the DSP back-to-back.
- Controls the pci accumulation loop and returns the 48-bit result through a valid/ready handshake.
- Sits between a host/control FSM and the DSP column.

Parameters:
- MAX_LEN, 256: maximum vector length per run.
- ADDR_W, $clog2(MAX_LEN): operand memory address width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- start  in  1  run request; sampled only in IDLE.
- len  in  ADDR_W+1  vector length; sampled with start; legal range 1..MAX_LEN.
- busy  out  1  high in every state except IDLE.
- err_len  out  1  one-cycle pulse when start is seen with an illegal len.
- rd_en  out  1  operand memory read strobe.
- rd_addr  out  ADDR_W  operand index.
- rd_a  in  25  signed a operand; valid the cycle after rd_en.
- rd_d  in  30  signed d operand; valid the cycle after rd_en.
- rd_b  in  18  signed b operand; valid the cycle after rd_en.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts the result.
- res_data  out  48  signed dot-product result.

Behaviour:
- Reset values: busy=0, err_len=0, rd_en=0, rd_addr=0, res_valid=0, res_data=0; FSM in IDLE; all tag pipelines cleared.
- FSM states: IDLE, ISSUE, DRAIN, HOLD.
- IDLE to ISSUE: start=1 and 1<=len<=MAX_LEN. The length is latched.
- IDLE, illegal len (start=1 with len=0 or len>MAX_LEN): err_len pulses in the next cycle; the FSM stays in IDLE.
- ISSUE:
  - rd_en=1 for exactly len consecutive cycles, with rd_addr = 0,1,...,len-1.
  - After the last issue, go to DRAIN.
  - No stalls or bubbles.
- Operand path:
  - rd_a, rd_d and rd_b connect directly to the DSP a, d and b inputs. They are meaningful only in the cycle after rd_en.
  - Inputs in other cycles are don't-care and are excluded from the sum by the tags.
- DSP timing, operands presented in cycle t:
  - pre-subtract register at t+2;
  - multiplier register m_q at t+3;
  - p updated at the end of cycle t+3 as m_q + pci. pci is used combinationally: USE_PCI_REG=0.
- Tag pipeline:
  - valid, first and last tags enter with rd_en and are delayed to align with m_q, i.e. 4 cycles after rd_en.
  - pci mux in that cycle: first tag set gives pci=0; otherwise pci=p (accumulate feedback).
- DRAIN: the FSM waits until the last tag leaves the p stage.
  - res_data is loaded from p in cycle s_last+5, where s_last is the last rd_en cycle.
  - res_valid rises in cycle s_last+6 and the FSM enters HOLD.
- Latency: start sampled in cycle 0 gives rd_en in cycles 1..len and res_valid in cycle len+6.
- HOLD:
  - res_valid=1 and res_data stays stable until res_ready=1.
  - On the handshake cycle, res_valid drops next cycle and the FSM returns to IDLE.
  - start is ignored in every non-IDLE state, including the handshake cycle.
- Arithmetic and widths:
  - a - d is truncated to 25-bit signed (wraps modulo 2^25); this is the DSP's own behaviour and is not compensated.
  - The product is 43-bit signed and is sign-extended into the 48-bit accumulator.
  - The accumulator wraps modulo 2^48; there is no saturation or overflow flag.
- Reset mid-run: the FSM goes to IDLE and the tags are cleared. Stale DSP pipeline contents never reach res_data. The next run is correct because its first tag zeroes pci.
- Back-to-back runs: no state carries over between runs; each run's result is independent.

Decomposition:
- Package dsp_mac_pkg holds:
  - constants A_W=25, D_W=30, B_W=18, P_W=48;
  - DSP_M_LAT=4, the cycles from rd_en to m_q alignment;
  - state enum typedef mac_state_t {IDLE, ISSUE, DRAIN, HOLD}.
- One sub-module instance: dsp_25x18_presub with USE_PCI_REG=0.
- The FSM, address counter, tag shift registers and pci mux live in the top level.

Test Plan:
- len=1 with a=10, d=3, b=5, start in cycle 0: rd_en only in cycle 1, rd_addr=0; res_valid in cycle 7 with res_data=35.
- len=3 with triples (7,2,4), (-5,1,3), (100,0,-2): res_data = 20 - 18 - 200 = -198; res_valid in cycle 9.
- Truncation: len=1, a=-2^24, d=1, b=1. Here a-d wraps to 2^24-1, so res_data=16777215.
- Backpressure: hold res_ready=0 for 5 cycles while pulsing start. res_data must stay stable, no rd_en may occur, and busy stays 1. Releasing res_ready gives one handshake, then IDLE.
- Back-to-back: run len=2 with result 50, then immediately a run len=1 with result 6. The second res_data must be 6, with no carry-over.
- Error and reset:
  - start with len=0 gives one err_len pulse and no rd_en.
  - rst asserted in cycle 3 of a len=4 run gives no res_valid.
  - A following len=1 run of (4,1,2) returns 6.
